// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback.
// Optional macro MULT_WATCHDOG_EN adds a multiplier timeout (MULT_TIMEOUT, mult_timeout).
module mips_multicycle_ctrl #(
  parameter int unsigned OPW  = 6,
  parameter int unsigned ST_W = 4
`ifdef MULT_WATCHDOG_EN
  ,
  parameter int unsigned MULT_TIMEOUT = 64
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic [OPW-1:0]  funct,
  input  logic            zero,
  input  logic            mem_ready,
  input  logic            mult_done,
  output logic            mem_read,
  output logic            mem_write,
  output logic            iord,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic            reg_write,
  output logic [1:0]      reg_dst,
  output logic [1:0]      mem_to_reg,
  output logic            mult_start,
  output logic            illegal_op,
`ifdef MULT_WATCHDOG_EN
  output logic            mult_timeout,
`endif
  output logic [ST_W-1:0] state_o
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,  StDecode = 4'd1,  StMemAdr = 4'd2,  StMemRd = 4'd3,
    StMemWb  = 4'd4,  StMemWr  = 4'd5,  StExecR  = 4'd6,  StAluWb = 4'd7,
    StExecI  = 4'd8,  StIwb    = 4'd9,  StBranch = 4'd10, StJump  = 4'd11,
    StJal    = 4'd12, StJr     = 4'd13, StMult   = 4'd14, StMwait = 4'd15
  } state_e;

  localparam logic [OPW-1:0] OpRtype = OPW'(6'h00);
  localparam logic [OPW-1:0] OpJ     = OPW'(6'h02);
  localparam logic [OPW-1:0] OpJal   = OPW'(6'h03);
  localparam logic [OPW-1:0] OpBeq   = OPW'(6'h04);
  localparam logic [OPW-1:0] OpBne   = OPW'(6'h05);
  localparam logic [OPW-1:0] OpAddi  = OPW'(6'h08);
  localparam logic [OPW-1:0] OpSlti  = OPW'(6'h0A);
  localparam logic [OPW-1:0] OpAndi  = OPW'(6'h0C);
  localparam logic [OPW-1:0] OpOri   = OPW'(6'h0D);
  localparam logic [OPW-1:0] OpLui   = OPW'(6'h0F);
  localparam logic [OPW-1:0] OpLw    = OPW'(6'h23);
  localparam logic [OPW-1:0] OpSw    = OPW'(6'h2B);
  localparam logic [OPW-1:0] FnJr    = OPW'(6'h08);
  localparam logic [OPW-1:0] FnMflo  = OPW'(6'h12);
  localparam logic [OPW-1:0] FnMult  = OPW'(6'h18);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_mflo;
  logic   r_illegal;
  logic   w_illegal_nxt;
  logic   w_is_r;
  logic   w_mflo_dec;
  logic   w_wd_expire;

  assign w_is_r     = (opcode == OpRtype);
  assign w_mflo_dec = w_is_r && (funct == FnMflo);

`ifdef MULT_WATCHDOG_EN
  logic [6:0] r_wd_cnt;
  logic       r_timeout;

  assign w_wd_expire = (r_state == StMwait) && !mult_done &&
                       (r_wd_cnt == 7'(MULT_TIMEOUT - 1));
  assign mult_timeout = r_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt  <= 7'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wd_expire;
      if (r_state == StMult) r_wd_cnt <= 7'd0;
      else if (r_state == StMwait) r_wd_cnt <= r_wd_cnt + 7'd1;
    end
  end
`else
  assign w_wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StFetch;
      r_mflo    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_illegal <= w_illegal_nxt;
      // mflo rides through ALUWB; the flag only retargets the writeback mux
      if (r_state == StDecode) r_mflo <= w_mflo_dec;
      else if (r_state == StAluWb) r_mflo <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_illegal_nxt = 1'b0;
    unique case (r_state)
      StFetch:  if (mem_ready) w_state_nxt = StDecode;
      StDecode: begin
        w_state_nxt = StFetch;
        if (w_is_r) begin
          if (funct == FnJr)        w_state_nxt = StJr;
          else if (funct == FnMult) w_state_nxt = StMult;
          else if (funct == FnMflo) w_state_nxt = StAluWb;
          else                      w_state_nxt = StExecR;
        end else begin
          case (opcode)
            OpLw, OpSw:                           w_state_nxt = StMemAdr;
            OpBeq, OpBne:                         w_state_nxt = StBranch;
            OpAddi, OpSlti, OpAndi, OpOri, OpLui: w_state_nxt = StExecI;
            OpJ:                                  w_state_nxt = StJump;
            OpJal:                                w_state_nxt = StJal;
            default:                              w_illegal_nxt = 1'b1;
          endcase
        end
      end
      StMemAdr: w_state_nxt = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) w_state_nxt = StMemWb;
      StMemWr:  if (mem_ready) w_state_nxt = StFetch;
      StExecR:  w_state_nxt = StAluWb;
      StExecI:  w_state_nxt = StIwb;
      StMult:   w_state_nxt = StMwait;
      StMwait:  if (mult_done || w_wd_expire) w_state_nxt = StFetch;
      default:  w_state_nxt = StFetch;
    endcase
  end

  // Outputs are forced low while reset is held, even though the state already reads FETCH.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    mult_start = 1'b0;
    if (reset) begin
      unique case (r_state)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        StDecode: alu_src_b = 2'd3;
        StMemAdr: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        StMemRd: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
        end
        StMemWr: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        StExecR: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd2;
        end
        StAluWb: begin
          reg_write  = 1'b1;
          reg_dst    = 2'd1;
          mem_to_reg = r_mflo ? 2'd3 : 2'd0;
        end
        StExecI: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = 2'd2;
        end
        StIwb: reg_write = 1'b1;
        StBranch: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd1;
          pc_src    = 2'd1;
          pc_write  = (opcode == OpBne) ? !zero : zero;
        end
        StJump: begin
          pc_src   = 2'd2;
          pc_write = 1'b1;
        end
        StJal: begin
          pc_src     = 2'd2;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
        StJr: begin
          pc_src   = 2'd3;
          pc_write = 1'b1;
        end
        StMult:  mult_start = 1'b1;
        StMwait: mult_start = 1'b0;
      endcase
    end
  end

  assign illegal_op = r_illegal;
  assign state_o    = ST_W'(r_state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, corner-case sequences and a
// randomized instruction stream checked cycle by cycle against an instruction-level model.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mult_done = 1'b0;
  logic       mem_read, mem_write, iord, ir_write, pc_write, alu_src_a, reg_write;
  logic       mult_start, illegal_op;
  logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic [3:0] state_o;
`ifdef MULT_WATCHDOG_EN
  logic       mult_timeout;
`endif

  typedef struct packed {
    logic       mr, mw, io, irw, pcw;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb, aop;
    logic       rw;
    logic [1:0] rd, mtr;
    logic       ms, ill;
  } ovec_t;

  ovec_t w_dut;
  assign w_dut = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                  alu_op, reg_write, reg_dst, mem_to_reg, mult_start, illegal_op};

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mult_done  (mult_done),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .mult_start (mult_start),
    .illegal_op (illegal_op),
`ifdef MULT_WATCHDOG_EN
    .mult_timeout (mult_timeout),
`endif
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int failures = 0;
  bit prev_ill = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Expected outputs of each state, straight from the state table.
  function automatic ovec_t spec_vec(input int st, input logic rdy, input logic z,
                                     input logic [5:0] op, input logic mflo, input logic ill);
    ovec_t v = '0;
    case (st)
      0:  begin v.mr = 1'b1; v.asb = 2'd1; v.irw = rdy; v.pcw = rdy; end
      1:  v.asb = 2'd3;
      2:  begin v.asa = 1'b1; v.asb = 2'd2; end
      3:  begin v.mr = 1'b1; v.io = 1'b1; end
      4:  begin v.rw = 1'b1; v.mtr = 2'd1; end
      5:  begin v.mw = 1'b1; v.io = 1'b1; end
      6:  begin v.asa = 1'b1; v.aop = 2'd2; end
      7:  begin v.rw = 1'b1; v.rd = 2'd1; v.mtr = mflo ? 2'd3 : 2'd0; end
      8:  begin v.asa = 1'b1; v.asb = 2'd2; v.aop = 2'd2; end
      9:  v.rw = 1'b1;
      10: begin v.asa = 1'b1; v.aop = 2'd1; v.pcs = 2'd1; v.pcw = (op == 6'h04) ? z : !z; end
      11: begin v.pcs = 2'd2; v.pcw = 1'b1; end
      12: begin v.pcs = 2'd2; v.pcw = 1'b1; v.rw = 1'b1; v.rd = 2'd2; v.mtr = 2'd2; end
      13: begin v.pcs = 2'd3; v.pcw = 1'b1; end
      14: v.ms = 1'b1;
      default: v = '0;
    endcase
    v.ill = ill;
    return v;
  endfunction

  typedef struct { int st; bit go; } step_t;

  function automatic step_t mk_step(input int s, input bit g);
    step_t r;
    r.st = s;
    r.go = g;
    return r;
  endfunction

  // Instruction-level model: phase list per instruction class, wait phases stretched by stalls.
  task automatic run_model(input logic [5:0] op, input logic [5:0] fn, input int fstall,
                           input int mstall, input int multn);
    step_t q[$];
    bit    mflo = 1'b0;
    bit    ill = 1'b0;
    int    ms;
    ovec_t ev;
    opcode = op;
    funct  = fn;
    for (int i = 0; i < fstall; i++) q.push_back(mk_step(0, 1'b0));
    q.push_back(mk_step(0, 1'b1));
    q.push_back(mk_step(1, 1'b0));
    if (op == 6'h00 && fn == 6'h08) q.push_back(mk_step(13, 1'b0));
    else if (op == 6'h00 && fn == 6'h18) begin
      q.push_back(mk_step(14, 1'b0));
      for (int i = 0; i < multn - 1; i++) q.push_back(mk_step(15, 1'b0));
      q.push_back(mk_step(15, 1'b1));
    end else if (op == 6'h00 && fn == 6'h12) begin
      mflo = 1'b1;
      q.push_back(mk_step(7, 1'b0));
    end else if (op == 6'h00) begin
      q.push_back(mk_step(6, 1'b0));
      q.push_back(mk_step(7, 1'b0));
    end else if (op inside {6'h23, 6'h2B}) begin
      ms = (op == 6'h23) ? 3 : 5;
      q.push_back(mk_step(2, 1'b0));
      for (int i = 0; i < mstall; i++) q.push_back(mk_step(ms, 1'b0));
      q.push_back(mk_step(ms, 1'b1));
      if (op == 6'h23) q.push_back(mk_step(4, 1'b0));
    end else if (op inside {6'h04, 6'h05}) q.push_back(mk_step(10, 1'b0));
    else if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F}) begin
      q.push_back(mk_step(8, 1'b0));
      q.push_back(mk_step(9, 1'b0));
    end else if (op == 6'h02) q.push_back(mk_step(11, 1'b0));
    else if (op == 6'h03) q.push_back(mk_step(12, 1'b0));
    else ill = 1'b1;
    foreach (q[i]) begin
      zero = 1'($urandom);
      if (q[i].st inside {0, 3, 5}) mem_ready = q[i].go;
      else mem_ready = 1'($urandom);
      mult_done = (q[i].st == 15) ? q[i].go : 1'($urandom);
      @(negedge clk);
      ev = spec_vec(q[i].st, mem_ready, zero, op, mflo, (i == 0) && prev_ill);
      check($sformatf("model op=%h fn=%h step=%0d {state,outs}", op, fn, i),
            32'({state_o, w_dut}), 32'({4'(q[i].st), ev}));
      @(posedge clk);
      #1;
    end
    prev_ill = ill;
  endtask

  // Runs one instruction from FETCH back to FETCH, with optional stalls, recording observations.
  task automatic run_dir(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int stall_st, input int stall_n, input int multn,
                         input int cap_st, output int n, output int ms_n, output int cap_n,
                         output ovec_t cap_v);
    int sc = 0;
    int mc = 0;
    bit left = 1'b0;
    opcode = op;
    funct  = fn;
    zero   = z;
    n = 0; ms_n = 0; cap_n = 0; cap_v = '0;
    while (n < 200) begin
      if (int'(state_o) == stall_st && sc < stall_n) begin
        mem_ready = 1'b0;
        sc++;
      end else mem_ready = 1'b1;
      mult_done = 1'b0;
      if (state_o == 4'd15) begin
        mult_done = (mc == multn - 1);
        mc++;
      end
      @(negedge clk);
      ms_n += int'(mult_start);
      if (int'(state_o) == cap_st) begin
        cap_n++;
        cap_v = w_dut;
      end
      @(posedge clk);
      #1;
      n++;
      if (state_o != 4'd0) left = 1'b1;
      else if (left) break;
    end
  endtask

  typedef struct {
    logic [5:0] op, fn;
    logic       z;
    int         stall_st, stall_n, multn, cap_st, exp_n, exp_cap_n, exp_ms;
    bit         mflo;
  } dvec_t;

  function automatic dvec_t dv(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input int sst, input int sn, input int mn, input int cst,
                               input int en, input int ecn, input int ems, input bit mflo);
    dvec_t d;
    d.op = op; d.fn = fn; d.z = z; d.stall_st = sst; d.stall_n = sn; d.multn = mn;
    d.cap_st = cst; d.exp_n = en; d.exp_cap_n = ecn; d.exp_ms = ems; d.mflo = mflo;
    return d;
  endfunction

  initial begin
    dvec_t      tbl[$];
    int         n, ms_n, cap_n;
    ovec_t      cap_v;
    ovec_t      ev;
    logic [5:0] ops [13] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A,
                             6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h03};
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h18, 6'h12};
    logic [5:0] op, fn;

    //            op     fn     z     sst sn mn cst  n  cn ms mflo
    tbl.push_back(dv(6'h00, 6'h20, 1'b0, -1, 0, 0, 7,  4, 1, 0, 1'b0)); // add
    tbl.push_back(dv(6'h23, 6'h00, 1'b0,  3, 2, 0, 3,  7, 3, 0, 1'b0)); // lw, MEMRD stalls
    tbl.push_back(dv(6'h23, 6'h00, 1'b0, -1, 0, 0, 4,  5, 1, 0, 1'b0)); // lw writeback
    tbl.push_back(dv(6'h2B, 6'h00, 1'b0,  0, 1, 0, 5,  5, 1, 0, 1'b0)); // sw, fetch stall
    tbl.push_back(dv(6'h04, 6'h00, 1'b1, -1, 0, 0, 10, 3, 1, 0, 1'b0)); // beq taken
    tbl.push_back(dv(6'h05, 6'h00, 1'b1, -1, 0, 0, 10, 3, 1, 0, 1'b0)); // bne not taken
    tbl.push_back(dv(6'h05, 6'h00, 1'b0, -1, 0, 0, 10, 3, 1, 0, 1'b0)); // bne taken
    tbl.push_back(dv(6'h08, 6'h00, 1'b0, -1, 0, 0, 9,  4, 1, 0, 1'b0)); // addi
    tbl.push_back(dv(6'h02, 6'h00, 1'b0, -1, 0, 0, 11, 3, 1, 0, 1'b0)); // j
    tbl.push_back(dv(6'h03, 6'h00, 1'b0, -1, 0, 0, 12, 3, 1, 0, 1'b0)); // jal
    tbl.push_back(dv(6'h00, 6'h08, 1'b0, -1, 0, 0, 13, 3, 1, 0, 1'b0)); // jr
    tbl.push_back(dv(6'h00, 6'h18, 1'b0, -1, 0, 5, 15, 8, 5, 1, 1'b0)); // mult, N=5
    tbl.push_back(dv(6'h00, 6'h12, 1'b0, -1, 0, 0, 7,  3, 1, 0, 1'b1)); // mflo
    tbl.push_back(dv(6'h3F, 6'h00, 1'b0, -1, 0, 0, 1,  2, 1, 0, 1'b0)); // illegal
    tbl.push_back(dv(6'h0F, 6'h00, 1'b0, -1, 0, 0, 8,  4, 1, 0, 1'b0)); // lui

    // Reset held: outputs low even with Mealy inputs asserted.
    mem_ready = 1'b1;
    zero      = 1'b1;
    opcode    = 6'h04;
    #12;
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_outputs", 32'(w_dut), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_reset_fetch", 32'({state_o, w_dut}),
          32'({4'd0, spec_vec(0, 1'b0, zero, opcode, 1'b0, 1'b0)}));
    @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      run_dir(tbl[k].op, tbl[k].fn, tbl[k].z, tbl[k].stall_st, tbl[k].stall_n, tbl[k].multn,
              tbl[k].cap_st, n, ms_n, cap_n, cap_v);
      ev = spec_vec(tbl[k].cap_st, 1'b1, tbl[k].z, tbl[k].op, tbl[k].mflo, 1'b0);
      check($sformatf("dir%0d_cycles", k), n, tbl[k].exp_n);
      check($sformatf("dir%0d_cap_cycles", k), cap_n, tbl[k].exp_cap_n);
      check($sformatf("dir%0d_mult_start_cycles", k), ms_n, tbl[k].exp_ms);
      check($sformatf("dir%0d_cap_outputs", k), 32'(cap_v), 32'(ev));
    end

    // Illegal opcode: one-cycle pulse in the FETCH that follows.
    run_dir(6'h3F, 6'h00, 1'b0, -1, 0, 0, 1, n, ms_n, cap_n, cap_v);
    mem_ready = 1'b0;
    @(negedge clk);
    check("illegal_pulse_on", 32'(illegal_op), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("illegal_pulse_off", 32'(illegal_op), 32'd0);
    @(posedge clk);
    #1;

`ifdef MULT_WATCHDOG_EN
    run_dir(6'h00, 6'h18, 1'b0, -1, 0, 0, 15, n, ms_n, cap_n, cap_v);
    check("wd_mwait_cycles", cap_n, 64);
    check("wd_total_cycles", n, 67);
    mem_ready = 1'b0;
    @(negedge clk);
    check("wd_timeout_on", 32'(mult_timeout), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wd_timeout_off", 32'(mult_timeout), 32'd0);
    @(posedge clk);
    #1;
`endif

    // Asynchronous reset in the middle of a stalled store.
    opcode    = 6'h2B;
    funct     = 6'h00;
    mem_ready = 1'b1;
    n = 0;
    while (state_o != 4'd5 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check("memwr_reached", 32'({state_o, mem_write}), 32'({4'd5, 1'b1}));
    #1 reset = 1'b0;
    #1;
    check("async_reset_outputs", 32'({state_o, w_dut}), 32'd0);
    @(posedge clk);
    #1;
    check("reset_hold_outputs", 32'({state_o, w_dut}), 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    prev_ill = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("release_fetch", 32'({state_o, w_dut}),
          32'({4'd0, spec_vec(0, 1'b0, zero, opcode, 1'b0, 1'b0)}));
    @(posedge clk);
    #1;

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 12)];
      if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
      else fn = fns[$urandom_range(0, 5)];
      run_model(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
